mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store sequencer sitting directly upstream of the 16-bit data memory.
//  Accepts one request at a time over a valid/ready handshake and drives the memory's write port
//  (Mwrite/Mdst/Mdst_addr) and read port (Msrc1_addr/Msrc1).
//  Supports 16-bit (narrow) and 32-bit (wide) accesses; a wide access is split into two consecutive words.
//  Hides the memory's 1-cycle synchronous read latency and returns a single response pulse per request.
// PARAMETERS
//  ADDR_W  21  word address width; matches the memory address ports
//  DATA_W  16  memory word width; wide accesses are 2*DATA_W
// PORTS
//  clk         in   1         clock; all state changes on posedge
//  rst         in   1         asynchronous, active-high reset
//  req_valid   in   1         request present
//  req_ready   out  1         unit can accept; 1 only in IDLE
//  req_write   in   1         1 = store, 0 = load
//  req_wide    in   1         1 = 32-bit access (addr, addr+1), 0 = 16-bit access
//  req_addr    in   ADDR_W    word address
//  req_wdata   in   2*DATA_W  store data; narrow uses [15:0]; wide: [15:0]->addr, [31:16]->addr+1
//  resp_valid  out  1         one-cycle completion pulse (loads and stores)
//  resp_rdata  out  2*DATA_W  load data; narrow zero-extended; wide {M[addr+1],M[addr]}
//  resp_err    out  1         misalignment error, qualified by resp_valid
//  Mwrite      out  1         memory write enable
//  Mdst        out  DATA_W    memory write data
//  Mdst_addr   out  ADDR_W    memory write address
//  Msrc1_addr  out  ADDR_W    memory read address
//  Msrc1       in   DATA_W    memory read data; valid the cycle after Msrc1_addr is sampled
// BEHAVIOUR
//  States: IDLE, ACC0, ACC1, DONE.
//  - Accept = req_valid & req_ready at posedge: latch write/wide/addr/wdata, go IDLE->ACC0.
//  - ACC0: Mdst_addr = Msrc1_addr = addr. Store: Mwrite=1, Mdst=wdata[15:0].
//    Next state is ACC1 if wide, else DONE.
//  - ACC1: address = addr+1, wrapping modulo 2^ADDR_W. Store: Mwrite=1, Mdst=wdata[31:16].
//    Load: capture Msrc1 (=M[addr]) into the low-half register. Next state is DONE.
//  - DONE: load loads resp_rdata, then go DONE->IDLE with resp_valid=1 for exactly one cycle.
//    Narrow load: resp_rdata = {16'h0, Msrc1}.
//    Wide load: resp_rdata = {Msrc1, lo}.
//    Stores: resp_rdata unchanged.
//  - Latency, accept edge to the edge that raises resp_valid: narrow = 2 clocks, wide = 3 clocks.
//    Next accept is possible on the edge after resp_valid rises.
//  - Mwrite=0 in IDLE and DONE.
//  - Address outputs hold the latched address outside the ACC states.
//  - resp_rdata holds until the next load response.
//  - No response backpressure: the consumer must take resp_valid when it occurs.
//  - req_* inputs are ignored while req_ready=0.
//  - Load following a store: the memory's write is complete before the next accept, so no hazard.
//  - Reset (any time, async): state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0,
//    latched addr/data=0, Mwrite=0 immediately.
//    A wide store interrupted in ACC1 leaves only the low word written. Accepted behaviour, no recovery.
// CONFIGURATION
//  MEM_ALIGN_CHK_EN defined:
//    - A wide request with req_addr[0]=1 goes IDLE->DONE with no memory access (Mwrite never asserted).
//    - Response: resp_valid=1, resp_err=1, resp_rdata=0.
//    - All other requests respond with resp_err=0.
//  MEM_ALIGN_CHK_EN undefined:
//    - resp_err is tied 0.
//    - Misaligned wide requests proceed normally (addr, addr+1).
// TESTING
//  Stimulus uses a behavioural 16-bit memory model with the Memory_Data port timing.
//  1. Reset, then narrow store 0xBEEF @0x00010, then narrow load @0x00010
//     -> one Mwrite pulse; load resp_rdata=0x0000BEEF, resp_valid 2 clocks after accept.
//  2. Wide store 0x12345678 @0x00020, then wide load @0x00020
//     -> M[0x20]=0x5678, M[0x21]=0x1234; load resp_rdata=0x12345678, 3 clocks after accept.
//  3. Wide load @0x1FFFFF
//     -> second read address wraps to 0x000000; resp_rdata={M[0],M[0x1FFFFF]}.
//  4. Hold req_valid=1 with back-to-back requests
//     -> req_ready=0 from accept until resp_valid; no request dropped or duplicated.
//  5. Assert rst during ACC1 of a wide store @0x30 (0xAAAA5555)
//     -> Mwrite drops immediately, M[0x30]=0x5555, M[0x31] unchanged, state IDLE, resp_valid=0.
//  6. MEM_ALIGN_CHK_EN: wide load @0x41 -> no memory access, resp_valid=1, resp_err=1, resp_rdata=0.
//     Without the macro, the same request returns {M[0x42],M[0x41]} with resp_err=0.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store sequencer in front of a 16-bit synchronous data
//               memory. Takes one request at a time over valid/ready and
//               drives the memory write port and read port. Narrow accesses
//               touch one word. Wide accesses touch two consecutive words.
//               Returns a single response pulse per request.
//               Optional feature macro: MEM_ALIGN_CHK_EN. When it is defined,
//               wide requests on an odd address are rejected with resp_err.
// Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit #(
   parameter int ADDR_W = 21,
   parameter int DATA_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic                req_wide,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0] req_wdata,
   output logic                resp_valid,
   output logic [2*DATA_W-1:0] resp_rdata,
   output logic                resp_err,
   output logic                Mwrite,
   output logic [DATA_W-1:0]   Mdst,
   output logic [ADDR_W-1:0]   Mdst_addr,
   output logic [ADDR_W-1:0]   Msrc1_addr,
   input  logic [DATA_W-1:0]   Msrc1
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC0 = 2'd1,
      S_ACC1 = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_write;
   logic                  r_wide;
   logic [ADDR_W-1:0]     r_addr;
   logic [2*DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]     r_lo;
   logic [2*DATA_W-1:0]   r_rdata;
   logic                  r_resp_valid;
   logic                  r_resp_err;
   logic                  w_accept;
   logic                  w_misalign_req;
   logic                  w_misalign;
   logic [ADDR_W-1:0]     w_addr_cur;

   assign w_accept = req_valid && (r_state == S_IDLE);

`ifdef MEM_ALIGN_CHK_EN
   logic r_misalign;

   assign w_misalign_req = req_wide & req_addr[0];
   assign w_misalign     = r_misalign;

   // Remember whether the accepted request is a rejected misaligned wide access
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_misalign <= 1'b0;
      end else if (w_accept) begin
         r_misalign <= w_misalign_req;
      end
   end
`else
   assign w_misalign_req = 1'b0;
   assign w_misalign     = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a rejected request skips the memory phases entirely
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = w_misalign_req ? S_DONE : S_ACC0;
         S_ACC0:  w_state_nxt = r_wide ? S_ACC1 : S_DONE;
         S_ACC1:  w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Memory port drive: second word of a wide access wraps around the address space
   always_comb begin
      w_addr_cur = r_addr;
      Mdst       = r_wdata[DATA_W-1:0];
      Mwrite     = 1'b0;
      if (r_state == S_ACC1) begin
         w_addr_cur = r_addr + ADDR_W'(1);
         Mdst       = r_wdata[2*DATA_W-1:DATA_W];
      end
      if ((r_state == S_ACC0) || (r_state == S_ACC1)) begin
         Mwrite = r_write;
      end
   end

   // Request latch, low-half capture and response generation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_write      <= 1'b0;
         r_wide       <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_lo         <= '0;
         r_rdata      <= '0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_write <= req_write;
            r_wide  <= req_wide;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
         end
         // Msrc1 during ACC1 carries the word read at the base address
         if (r_state == S_ACC1) begin
            r_lo <= Msrc1;
         end
         r_resp_valid <= (r_state == S_DONE);
         if (r_state == S_DONE) begin
            r_resp_err <= w_misalign;
            if (w_misalign) begin
               r_rdata <= '0;
            end else if (!r_write) begin
               r_rdata <= r_wide ? {Msrc1, r_lo} : {{DATA_W{1'b0}}, Msrc1};
            end
         end
      end
   end

   assign req_ready  = (r_state == S_IDLE);
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_rdata;
   assign resp_err   = r_resp_err;
   assign Mdst_addr  = w_addr_cur;
   assign Msrc1_addr = w_addr_cur;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. It uses a 16-bit
//               synchronous memory and a transaction-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;
   localparam int AW = 21;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic          req_wide = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [31:0]   req_wdata = '0;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_err;
   logic          Mwrite;
   logic [DW-1:0] Mdst;
   logic [AW-1:0] Mdst_addr;
   logic [AW-1:0] Msrc1_addr;
   logic [DW-1:0] Msrc1 = '0;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .Mwrite(Mwrite), .Mdst(Mdst), .Mdst_addr(Mdst_addr),
      .Msrc1_addr(Msrc1_addr), .Msrc1(Msrc1)
   );

   // Memory seen by the DUT, and the reference model's view of the same memory
   logic [DW-1:0] mem     [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];

   function automatic logic [15:0] init_val(input logic [AW-1:0] a);
      return a[15:0] ^ 16'h5A3C;
   endfunction

   // Synchronous memory: one-cycle read latency, write on the edge
   always @(posedge clk) begin
      if (Mwrite) mem[Mdst_addr] <= Mdst;
      Msrc1 <= mem[Msrc1_addr];
   end

   int cyc = 0;
   int wr_count = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (Mwrite) wr_count <= wr_count + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int          due;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        q[$];
   logic [31:0] model_rdata = '0;
   bit          chk_en = 1'b0;
   int          resp_seen = 0;
   logic [31:0] last_rdata = '0;
   logic        last_err = 1'b0;

   always @(negedge clk) begin
      bit due_now;
      if (chk_en) begin
         due_now = (q.size() > 0) && (q[0].due == cyc);
         check("resp_valid", {31'd0, resp_valid}, {31'd0, due_now});
         check("req_ready", {31'd0, req_ready}, {31'd0, (q.size() == 0) || due_now});
         if (q.size() == 0) check("mwrite_idle", {31'd0, Mwrite}, 32'd0);
         if (due_now) begin
            check("resp_rdata", resp_rdata, q[0].rdata);
            check("resp_err", {31'd0, resp_err}, {31'd0, q[0].err});
            last_rdata = resp_rdata;
            last_err   = resp_err;
            resp_seen++;
            void'(q.pop_front());
         end else if ((q.size() > 0) && (q[0].due < cyc)) begin
            void'(q.pop_front());
         end
      end
   end

   task automatic issue(input bit w, input bit wide, input logic [AW-1:0] a,
                        input logic [31:0] wd, input bit keep);
      int            n;
      int            lat;
      bit            misal;
      exp_t          e;
      logic [AW-1:0] a1;
      n = 0;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_wide = wide; req_addr = a; req_wdata = wd;
      while (!req_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: got ready=0 expected ready=1 addr=%h", a);
         req_valid = 1'b0;
         return;
      end
      e.due = cyc + 1;
      @(posedge clk);
      #1;
      a1 = a + 21'd1;
`ifdef MEM_ALIGN_CHK_EN
      misal = wide && a[0];
`else
      misal = 1'b0;
`endif
      e.err = misal;
      if (misal) begin
         lat = 1;
         model_rdata = '0;
      end else begin
         lat = wide ? 3 : 2;
         if (w) begin
            ref_mem[a] = wd[15:0];
            if (wide) ref_mem[a1] = wd[31:16];
         end else begin
            model_rdata = wide ? {ref_mem[a1], ref_mem[a]} : {16'h0, ref_mem[a]};
         end
      end
      e.due   = e.due + lat;
      e.rdata = model_rdata;
      q.push_back(e);
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (q.size() > 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL resp_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int wr0;
      int seen0;
      int addrs[10];
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i]     = init_val(AW'(i));
         ref_mem[i] = init_val(AW'(i));
      end

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_err", {31'd0, resp_err}, 32'd0);
      check("rst_mwrite", {31'd0, Mwrite}, 32'd0);
      rst = 1'b0;
      chk_en = 1'b1;

      // 1: narrow store then narrow load
      wr0 = wr_count;
      issue(1'b1, 1'b0, 21'h00010, 32'h0000BEEF, 1'b0);
      wait_idle();
      check("t1_write_pulses", wr_count - wr0, 32'd1);
      issue(1'b0, 1'b0, 21'h00010, 32'h0, 1'b0);
      wait_idle();
      check("t1_load", last_rdata, 32'h0000BEEF);

      // 2: wide store then wide load
      issue(1'b1, 1'b1, 21'h00020, 32'h12345678, 1'b0);
      wait_idle();
      check("t2_mem_lo", {16'h0, mem[21'h20]}, 32'h5678);
      check("t2_mem_hi", {16'h0, mem[21'h21]}, 32'h1234);
      issue(1'b0, 1'b1, 21'h00020, 32'h0, 1'b0);
      wait_idle();
      check("t2_load", last_rdata, 32'h12345678);

      // 3: wide load across the top of the address space
      issue(1'b0, 1'b1, 21'h1FFFFF, 32'h0, 1'b0);
      wait_idle();
      check("t3_wrap_load", last_rdata, 32'h5A3CA5C3);

      // 4: back-to-back requests with req_valid held high
      seen0 = resp_seen;
      issue(1'b1, 1'b0, 21'h00050, 32'h00001111, 1'b1);
      issue(1'b0, 1'b1, 21'h00020, 32'h0, 1'b1);
      issue(1'b0, 1'b0, 21'h00050, 32'h0, 1'b1);
      issue(1'b1, 1'b1, 21'h00060, 32'hCAFED00D, 1'b0);
      wait_idle();
      check("t4_resp_count", resp_seen - seen0, 32'd4);
      check("t4_rdata_held", last_rdata, 32'h00001111);

      // 5: reset in the middle of a wide store
      chk_en = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_wide = 1'b1;
      req_addr = 21'h00030; req_wdata = 32'hAAAA5555;
      check("t5_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 check("t5_mwrite_acc1", {31'd0, Mwrite}, 32'd1);
      #2 rst = 1'b1;
      #1 check("t5_mwrite_drop", {31'd0, Mwrite}, 32'd0);
      check("t5_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("t5_ready_idle", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("t5_mem_lo", {16'h0, mem[21'h30]}, 32'h5555);
      check("t5_mem_hi", {16'h0, mem[21'h31]}, 32'h5A0D);
      ref_mem[21'h30] = 16'h5555;
      model_rdata = '0;
      chk_en = 1'b1;
      issue(1'b0, 1'b1, 21'h00030, 32'h0, 1'b0);
      wait_idle();
      check("t5_reload", last_rdata, 32'h5A0D5555);

      // 6: misaligned wide requests
      wr0 = wr_count;
      issue(1'b0, 1'b1, 21'h00041, 32'h0, 1'b0);
      wait_idle();
`ifdef MEM_ALIGN_CHK_EN
      check("t6_rdata", last_rdata, 32'h0);
      check("t6_err", {31'd0, last_err}, 32'd1);
      issue(1'b1, 1'b1, 21'h00043, 32'h77776666, 1'b0);
      wait_idle();
      check("t6_no_write", wr_count - wr0, 32'd0);
      check("t6_mem_kept", {16'h0, mem[21'h43]}, 32'h5A7F);
`else
      check("t6_rdata", last_rdata, 32'h5A7E5A7D);
      check("t6_err", {31'd0, last_err}, 32'd0);
`endif

      // Final memory image against the reference model
      addrs = '{32'h10, 32'h20, 32'h21, 32'h30, 32'h31, 32'h50, 32'h60, 32'h61, 32'h0, 32'h1FFFFF};
      foreach (addrs[i]) begin
         check("mem_image", {16'h0, mem[AW'(addrs[i])]}, {16'h0, ref_mem[AW'(addrs[i])]});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
